multicycle_control_hs: RTL and testbench
========================================

Name: multicycle_control_hs

Overview:
- Next-generation multicycle control FSM for the single-issue computer.
- Generalises the fixed-latency controller with a parametrised opcode width and ready handshakes on instruction and data memory.
- Adds a wait-state timeout watchdog, an in-band program-load mode, a HALT instruction, a sticky FAULT state and an instruction-retired strobe.
- Drives the same datapath enables as the existing controller; sits between IR/opcode decode and the datapath/memories.

Parameters:
OPCODE_W, 4, opcode width in bits (min 4); encodings occupy bits [3:0], all upper bits must be 0 for a legal opcode
WAIT_TIMEOUT, 16, max consecutive not-ready cycles tolerated in any wait state before FAULT (range 2..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
program_mode  in  1  request instruction-memory load mode
prog_valid  in  1  program word present on imem write bus (PROG state only)
opcode  in  OPCODE_W  current IR opcode
result_lsb  in  1  ALU-out register bit 0 (branch condition)
imem_ready  in  1  instruction memory read complete
dmem_ready  in  1  data memory access complete
ir_enable, dmem_read, dmem_write, imem_read, imem_write, pc_increment, alu_reg_enable, pc_enable, alu_src_B, alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable  out  1 each  datapath controls, meanings unchanged from the existing controller
select_reg_write_data  out  2  00 dmem, 01 immediate, 10 alu_out
instr_retired  out  1  one-cycle pulse when an instruction completes
halted  out  1  in HALT state
fault  out  1  in FAULT state (sticky)
state_out  out  4  current state encoding, for debug

Behaviour:
- Opcode encodings (bits [3:0]): NOP 0, ADD 1, ADDI 2, LW 3, LI 4, SW 5, BLEQ 6, HALT 7. Values 8-15 and any nonzero upper bit are illegal.
- State encodings: BOOT 0, PROG 1, FETCH 2, DECODE 3, AOPB 4, AOPIMM 5, LOADW 6, LOADI 7, STOREW 8, BRANCH 9, RTYPE 10, HALT 11, FAULT 12.
- Reset low: state BOOT; every output 0, including state_out 0.
- All outputs are registered. They are computed from the next state on each clock edge, so they are valid during the cycle the FSM occupies that state.
- Transitions:
  - BOOT->PROG if program_mode, else FETCH.
  - Every transition that would enter FETCH goes to PROG instead if program_mode=1 on that edge.
  - PROG: imem_write=prog_valid sampled that edge; stays while program_mode=1; ->FETCH when it drops.
  - FETCH: imem_read=1, ir_enable=1; stays until imem_ready=1, then ->DECODE.
  - DECODE: pc_increment=1, alu_reg_enable=1, for one cycle. ADD/BLEQ->AOPB; ADDI->AOPIMM; LW->LOADW; LI->LOADI; SW->STOREW; NOP->FETCH with instr_retired; HALT->HALT with instr_retired; illegal->FETCH with instr_retired (treated as NOP).
  - AOPB: alu_out_reg_enable=1. BLEQ->BRANCH; ADD->RTYPE.
  - AOPIMM: alu_out_reg_enable=1, alu_src_B=1; ->RTYPE.
  - LOADW: dmem_read=1, dmem_out_reg_enable=1 until dmem_ready. On the ready cycle reg_write_enable=1 and select=00; ->FETCH.
  - STOREW: dmem_write=1 until dmem_ready; ->FETCH.
  - LOADI: reg_write_enable=1, select=01; ->FETCH.
  - RTYPE: reg_write_enable=1, select=10; ->FETCH.
  - BRANCH: pc_enable=result_lsb sampled on entry edge; ->FETCH.
  - instr_retired pulses on the edge leaving LOADW, STOREW, LOADI, RTYPE or BRANCH, and as listed for DECODE.
  - HALT: all controls 0, halted=1; stays until program_mode=1 (->PROG) or reset.
- Watchdog:
  - Counter clears on entry to FETCH, LOADW and STOREW, and increments each cycle ready is low.
  - When the count reaches WAIT_TIMEOUT with ready still low, ->FAULT.
  - Ready arriving on the same cycle the limit is hit wins: normal transition, no FAULT.
- FAULT: all controls 0, fault=1; exits only on reset. program_mode is ignored.
- program_mode asserted mid-instruction has no effect until the instruction retires.
- Async reset mid-wait aborts immediately: outputs drop to 0 without waiting for a clock edge.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to FAULT, with no instr_retired pulse.
- Undefined: an illegal opcode behaves as NOP, as specified above.

Test Plan:
- Reset low for 3 cycles, release, imem_ready tied 1: outputs all 0 during reset; state_out sequence 0,2,3. NOP retires with instr_retired=1 for one cycle, 3 cycles after release.
- ADDI, ready=1: AOPIMM asserts alu_src_B=1 and alu_out_reg_enable=1. RTYPE asserts reg_write_enable=1 with select=10. instr_retired pulses; total 4 cycles FETCH to FETCH.
- LW with dmem_ready held low 5 cycles, then 1: dmem_read stays high for exactly 6 cycles. reg_write_enable high only on the ready cycle; no FAULT.
- FETCH with imem_ready never asserted, WAIT_TIMEOUT=16: fault=1 and state_out=12 after 16 cycles. Remains so with program_mode toggled, until reset goes low.
- BLEQ twice, result_lsb=1 then 0: pc_enable=1 for one cycle in the first BRANCH, 0 in the second.
- HALT, then program_mode=1 with 3 prog_valid pulses, then program_mode=0: halted=1, then PROG with 3 imem_write pulses each lagging prog_valid by one cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_control_hs.sv
// Multicycle control FSM with imem/dmem ready handshakes, wait-state watchdog, program-load mode, HALT and sticky FAULT.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to FAULT instead of retiring as NOP.
module multicycle_control_hs #(
  parameter int OPCODE_W     = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                program_mode,
  input  logic                prog_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                result_lsb,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                ir_enable,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                imem_read,
  output logic                imem_write,
  output logic                pc_increment,
  output logic                alu_reg_enable,
  output logic                pc_enable,
  output logic                alu_src_B,
  output logic                alu_out_reg_enable,
  output logic                dmem_out_reg_enable,
  output logic                reg_write_enable,
  output logic [1:0]          select_reg_write_data,
  output logic                instr_retired,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          state_out
);

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_PROG   = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_AOPB   = 4'd4,
    S_AOPIMM = 4'd5,
    S_LOADW  = 4'd6,
    S_LOADI  = 4'd7,
    S_STOREW = 4'd8,
    S_BRANCH = 4'd9,
    S_RTYPE  = 4'd10,
    S_HALT   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LI   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BLEQ = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam int C_IR  = 11;
  localparam int C_DRD = 10;
  localparam int C_DWR = 9;
  localparam int C_IRD = 8;
  localparam int C_IWR = 7;
  localparam int C_PCI = 6;
  localparam int C_ARE = 5;
  localparam int C_PCE = 4;
  localparam int C_ASB = 3;
  localparam int C_AOE = 2;
  localparam int C_DOE = 1;
  localparam int C_RWE = 0;

  localparam logic [7:0] WDOG_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t                state, state_next;
  logic [7:0]            wdog_cnt;
  logic                  timeout, retire, load_done, op_legal;
  logic [3:0]            op_lo;
  logic [OPCODE_W-1:0]   op_upper;
  logic [11:0]           ctrl_d, ctrl_q;
  logic [1:0]            sel_d, sel_q;
  logic                  retired_q, halted_q, fault_q;

  assign op_lo    = opcode[3:0];
  assign op_upper = opcode >> 4;
  assign op_legal = (op_upper == '0) && !op_lo[3];
  assign timeout  = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_next;
  end

  // Count consecutive not-ready cycles while parked in a wait state; any entry or exit clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wdog_cnt <= '0;
    else if ((state_next == state) &&
             (state == S_FETCH || state == S_LOADW || state == S_STOREW))
      wdog_cnt <= wdog_cnt + 8'd1;
    else
      wdog_cnt <= '0;
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      S_BOOT:   state_next = S_FETCH;
      S_PROG:   if (!program_mode) state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready)   state_next = S_DECODE;
        else if (timeout) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (!op_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = S_FAULT;
`else
          state_next = S_FETCH;
          retire     = 1'b1;
`endif
        end else begin
          unique case (op_lo)
            OP_ADD, OP_BLEQ: state_next = S_AOPB;
            OP_ADDI:         state_next = S_AOPIMM;
            OP_LW:           state_next = S_LOADW;
            OP_LI:           state_next = S_LOADI;
            OP_SW:           state_next = S_STOREW;
            OP_HALT: begin
              state_next = S_HALT;
              retire     = 1'b1;
            end
            default: begin
              state_next = S_FETCH;
              retire     = 1'b1;
            end
          endcase
        end
      end
      S_AOPB:   state_next = (op_lo == OP_BLEQ) ? S_BRANCH : S_RTYPE;
      S_AOPIMM: state_next = S_RTYPE;
      S_LOADW: begin
        if (dmem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
          load_done  = 1'b1;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_STOREW: begin
        if (dmem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_LOADI, S_RTYPE, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:   if (program_mode) state_next = S_PROG;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FAULT;
    endcase
    if (state_next == S_FETCH && program_mode)
      state_next = S_PROG;
  end

  // Outputs are decoded from the state being entered so the registered copy lines up with that state.
  always_comb begin
    ctrl_d = '0;
    sel_d  = 2'b00;
    unique case (state_next)
      S_PROG:   ctrl_d[C_IWR] = prog_valid;
      S_FETCH: begin
        ctrl_d[C_IR]  = 1'b1;
        ctrl_d[C_IRD] = 1'b1;
      end
      S_DECODE: begin
        ctrl_d[C_PCI] = 1'b1;
        ctrl_d[C_ARE] = 1'b1;
      end
      S_AOPB:   ctrl_d[C_AOE] = 1'b1;
      S_AOPIMM: begin
        ctrl_d[C_AOE] = 1'b1;
        ctrl_d[C_ASB] = 1'b1;
      end
      S_LOADW: begin
        ctrl_d[C_DRD] = 1'b1;
        ctrl_d[C_DOE] = 1'b1;
      end
      S_STOREW: ctrl_d[C_DWR] = 1'b1;
      S_LOADI: begin
        ctrl_d[C_RWE] = 1'b1;
        sel_d         = 2'b01;
      end
      S_RTYPE: begin
        ctrl_d[C_RWE] = 1'b1;
        sel_d         = 2'b10;
      end
      S_BRANCH: ctrl_d[C_PCE] = result_lsb;
      default:  ;
    endcase
    if (load_done)
      ctrl_d[C_RWE] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      sel_q     <= 2'b00;
      retired_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      sel_q     <= sel_d;
      retired_q <= retire;
      halted_q  <= (state_next == S_HALT);
      fault_q   <= (state_next == S_FAULT);
    end
  end

  assign ir_enable             = ctrl_q[C_IR];
  assign dmem_read             = ctrl_q[C_DRD];
  assign dmem_write            = ctrl_q[C_DWR];
  assign imem_read             = ctrl_q[C_IRD];
  assign imem_write            = ctrl_q[C_IWR];
  assign pc_increment          = ctrl_q[C_PCI];
  assign alu_reg_enable        = ctrl_q[C_ARE];
  assign pc_enable             = ctrl_q[C_PCE];
  assign alu_src_B             = ctrl_q[C_ASB];
  assign alu_out_reg_enable    = ctrl_q[C_AOE];
  assign dmem_out_reg_enable   = ctrl_q[C_DOE];
  assign reg_write_enable      = ctrl_q[C_RWE];
  assign select_reg_write_data = sel_q;
  assign instr_retired         = retired_q;
  assign halted                = halted_q;
  assign fault                 = fault_q;
  assign state_out             = state;

endmodule

// File: tb/tb_multicycle_control_hs.sv
// Scoreboard bench for multicycle_control_hs: per-cycle stimulus and expected output words are queued, then popped after each edge.
module tb_multicycle_control_hs;

  localparam int OPW  = 5;
  localparam int WTO  = 16;

  localparam logic [4:0] NOP = 5'd0, ADDI = 5'd2, LW = 5'd3, LI = 5'd4,
                         SW = 5'd5, BLEQ = 5'd6, HALT = 5'd7;

  localparam logic [11:0] C_FETCH  = 12'h900;
  localparam logic [11:0] C_DECODE = 12'h060;
  localparam logic [11:0] C_AOPB   = 12'h004;
  localparam logic [11:0] C_AOPIMM = 12'h00C;
  localparam logic [11:0] C_LOADW  = 12'h402;
  localparam logic [11:0] C_STOREW = 12'h200;
  localparam logic [11:0] C_WE     = 12'h001;
  localparam logic [11:0] C_PCEN   = 12'h010;
  localparam logic [11:0] C_IMW    = 12'h080;

  typedef struct packed {
    logic       pm;
    logic       pv;
    logic       ir;
    logic       dr;
    logic       rl;
    logic [4:0] op;
  } stim_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] ctl;
    logic [1:0]  sel;
    logic        ret;
    logic        hlt;
    logic        flt;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           program_mode, prog_valid, result_lsb, imem_ready, dmem_ready;
  logic [OPW-1:0] opcode;
  logic ir_enable, dmem_read, dmem_write, imem_read, imem_write, pc_increment;
  logic alu_reg_enable, pc_enable, alu_src_B, alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable;
  logic [1:0] select_reg_write_data;
  logic instr_retired, halted, fault;
  logic [3:0] state_out;
  exp_t obs;

  stim_t stim_q[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;

  multicycle_control_hs #(.OPCODE_W(OPW), .WAIT_TIMEOUT(WTO)) dut (
    .clk(clk), .reset(reset), .program_mode(program_mode), .prog_valid(prog_valid),
    .opcode(opcode), .result_lsb(result_lsb), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_enable(ir_enable), .dmem_read(dmem_read), .dmem_write(dmem_write), .imem_read(imem_read),
    .imem_write(imem_write), .pc_increment(pc_increment), .alu_reg_enable(alu_reg_enable),
    .pc_enable(pc_enable), .alu_src_B(alu_src_B), .alu_out_reg_enable(alu_out_reg_enable),
    .dmem_out_reg_enable(dmem_out_reg_enable), .reg_write_enable(reg_write_enable),
    .select_reg_write_data(select_reg_write_data), .instr_retired(instr_retired),
    .halted(halted), .fault(fault), .state_out(state_out)
  );

  always #5 clk = ~clk;

  assign obs = {state_out, ir_enable, dmem_read, dmem_write, imem_read, imem_write, pc_increment,
                alu_reg_enable, pc_enable, alu_src_B, alu_out_reg_enable, dmem_out_reg_enable,
                reg_write_enable, select_reg_write_data, instr_retired, halted, fault};

  function automatic stim_t s(input logic pm, input logic pv, input logic ir, input logic dr,
                              input logic rl, input logic [4:0] op);
    s = '{pm: pm, pv: pv, ir: ir, dr: dr, rl: rl, op: op};
  endfunction

  function automatic exp_t mk(input logic [3:0] st, input logic [11:0] ctl, input logic [1:0] sel,
                              input logic ret, input logic hlt, input logic flt);
    mk = '{st: st, ctl: ctl, sel: sel, ret: ret, hlt: hlt, flt: flt};
  endfunction

  task automatic plan(input stim_t st, input exp_t ex);
    stim_q.push_back(st);
    sb.push_back(ex);
  endtask

  task automatic drive(input stim_t st);
    program_mode = st.pm;
    prog_valid   = st.pv;
    imem_ready   = st.ir;
    dmem_ready   = st.dr;
    result_lsb   = st.rl;
    opcode       = st.op;
  endtask

  task automatic test_reset();
    exp_t want;
    int   cyc = 0;
    for (int i = 0; i < 3; i++) plan(s(0,0,1,0,0,NOP), '0);
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL reset_hold cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
    reset = 1'b1;
    plan(s(0,0,1,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,NOP), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL reset_nop cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_addi();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,ADDI), mk(4'd3,  C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,ADDI), mk(4'd5,  C_AOPIMM, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,ADDI), mk(4'd10, C_WE,     2'b10, 0,0,0));
    plan(s(0,0,1,0,0,ADDI), mk(4'd2,  C_FETCH,  2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL addi cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_lw_wait();
    exp_t want;
    int   cyc = 0, rd_cnt = 0, we_cnt = 0;
    plan(s(0,0,1,0,0,LW), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    for (int i = 0; i < 6; i++) plan(s(0,0,1,0,0,LW), mk(4'd6, C_LOADW, 2'b00, 0,0,0));
    plan(s(0,0,1,1,0,LW), mk(4'd2, C_FETCH | C_WE, 2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      rd_cnt += int'(dmem_read);
      we_cnt += int'(reg_write_enable);
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL lw_wait cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
    total++;
    if (rd_cnt !== 6) begin
      bad++;
      $display("[TB] FAIL lw_read_cycles: got=%0d want=6", rd_cnt);
    end
    total++;
    if (we_cnt !== 1) begin
      bad++;
      $display("[TB] FAIL lw_write_cycles: got=%0d want=1", we_cnt);
    end
  endtask

  task automatic test_store_boundary();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,SW), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,SW), mk(4'd8, C_STOREW, 2'b00, 0,0,0));
    for (int i = 0; i < WTO - 1; i++) plan(s(0,0,1,0,0,SW), mk(4'd8, C_STOREW, 2'b00, 0,0,0));
    plan(s(0,0,1,1,0,SW), mk(4'd2, C_FETCH, 2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL store_boundary cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_bleq(input logic rl);
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,rl,BLEQ), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,rl,BLEQ), mk(4'd4, C_AOPB,   2'b00, 0,0,0));
    plan(s(0,0,1,0,rl,BLEQ), mk(4'd9, rl ? C_PCEN : 12'h000, 2'b00, 0,0,0));
    plan(s(0,0,1,0,rl,BLEQ), mk(4'd2, C_FETCH,  2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL bleq_lsb%0d cyc%0d: got=%h want=%h", rl, cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_li_deferred_prog();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,LI), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(1,0,1,0,0,LI), mk(4'd7, C_WE,     2'b01, 0,0,0));
    plan(s(1,0,1,0,0,LI), mk(4'd1, 12'h000,  2'b00, 1,0,0));
    plan(s(0,0,1,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 0,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL li_deferred cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_illegal_opcode();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,5'b10001), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,5'b10001), mk(4'd2, C_FETCH,  2'b00, 1,0,0));
    plan(s(0,0,1,0,0,5'b01001), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,5'b01001), mk(4'd2, C_FETCH,  2'b00, 1,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL illegal_op cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_halt_prog();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,HALT), mk(4'd3,  C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,HALT), mk(4'd11, 12'h000,  2'b00, 1,1,0));
    plan(s(0,0,1,0,0,HALT), mk(4'd11, 12'h000,  2'b00, 0,1,0));
    plan(s(0,0,1,0,0,HALT), mk(4'd11, 12'h000,  2'b00, 0,1,0));
    plan(s(1,0,1,0,0,HALT), mk(4'd1,  12'h000,  2'b00, 0,0,0));
    for (int i = 0; i < 3; i++) begin
      plan(s(1,1,1,0,0,HALT), mk(4'd1, C_IMW,   2'b00, 0,0,0));
      plan(s(1,0,1,0,0,HALT), mk(4'd1, 12'h000, 2'b00, 0,0,0));
    end
    plan(s(0,0,1,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 0,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL halt_prog cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
  endtask

  task automatic test_async_abort();
    exp_t want;
    int   cyc = 0;
    plan(s(0,0,1,0,0,LW), mk(4'd3, C_DECODE, 2'b00, 0,0,0));
    plan(s(0,0,1,0,0,LW), mk(4'd6, C_LOADW,  2'b00, 0,0,0));
    plan(s(0,0,1,0,0,LW), mk(4'd6, C_LOADW,  2'b00, 0,0,0));
    plan(s(0,0,1,0,0,LW), mk(4'd6, C_LOADW,  2'b00, 0,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL async_wait cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (obs !== exp_t'('0)) begin
      bad++;
      $display("[TB] FAIL async_abort_immediate: got=%h want=0", obs);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    plan(s(0,0,1,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 0,0,0));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL async_recover: got=%h want=%h", obs, want);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    exp_t want;
    int   cyc = 0;
    for (int i = 0; i < WTO - 1; i++) plan(s(0,0,0,0,0,NOP), mk(4'd2, C_FETCH, 2'b00, 0,0,0));
    plan(s(0,0,0,0,0,NOP), mk(4'd12, 12'h000, 2'b00, 0,0,1));
    for (int i = 0; i < 4; i++) plan(s(~i[0],0,1,1,0,NOP), mk(4'd12, 12'h000, 2'b00, 0,0,1));
    while (sb.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("[TB] FAIL fetch_timeout cyc%0d: got=%h want=%h", cyc, obs, want);
      end
      cyc++;
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (obs !== exp_t'('0)) begin
      bad++;
      $display("[TB] FAIL fault_reset_clear: got=%h want=0", obs);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL bench_timeout: simulation did not complete in time");
    $fatal(1, "[TB] bench timeout");
  end

  initial begin
    reset = 1'b0;
    drive(s(0,0,1,0,0,NOP));
    test_reset();
    test_addi();
    test_lw_wait();
    test_store_boundary();
    test_bleq(1'b1);
    test_bleq(1'b0);
    test_li_deferred_prog();
    test_illegal_opcode();
    test_halt_prog();
    test_async_abort();
    test_fetch_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
